// File: rtl/mem_responder.sv
// Single-port word memory responder for the multicycle core: one request at a time,
// LATENCY wait states, then a one-cycle Ready strobe carrying RData/Err.
`timescale 1ns/1ps
module mem_responder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;

    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_adr;
    logic [31:0]       acc_wdata;
    logic              acc_fault;
    logic [IDX_W-1:0]  acc_idx;
    logic              mem_we;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       mem_rd_q;

    // With LATENCY=0 the access happens on the accepting edge, so the live inputs
    // are used in IDLE; otherwise the captured request drives the access.
    always_comb begin
        acc_we    = we_q;
        acc_adr   = adr_q;
        acc_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_we    = we_i;
            acc_adr   = adr_i;
            acc_wdata = wdata_i;
        end
        acc_fault = (acc_adr[1:0] != 2'b00) ||
                    ({2'b00, acc_adr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
        acc_idx   = acc_adr[IDX_W+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        rd_valid_d = 1'b0;
        acc_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    adr_d   = adr_i;
                    wdata_d = wdata_i;
                    busy_d  = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        acc_en  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    acc_en  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (acc_en) begin
            ready_d    = 1'b1;
            busy_d     = 1'b1;
            err_d      = acc_fault;
            rd_valid_d = !acc_we && !acc_fault;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is never reset; the write is blocked while reset is held so an
    // unaccepted request cannot slip into memory.
    always_comb begin
        mem_we = acc_en && acc_we && !acc_fault && rst_ni;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
        mem_rd_q <= mem[acc_idx];
    end

    assign rdata_o = rd_valid_q ? mem_rd_q : 32'd0;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance share one stimulus stream
// and are checked every cycle against a cycle-countdown transaction model.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] d_rdata [2];
    logic        d_ready [2];
    logic        d_err   [2];
    logic        d_busy  [2];

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(2), .INIT_FILE("")) u_lat2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .adr_i(adr), .wdata_i(wdata),
        .rdata_o(d_rdata[0]), .ready_o(d_ready[0]), .err_o(d_err[0]), .busy_o(d_busy[0])
    );

    mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(0), .INIT_FILE("")) u_lat0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .adr_i(adr), .wdata_i(wdata),
        .rdata_o(d_rdata[1]), .ready_o(d_ready[1]), .err_o(d_err[1]), .busy_o(d_busy[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining busy cycles per instance; the access happens when the count reaches 1.
    int          m_remain [2];
    logic        m_ready  [2];
    logic        m_busy   [2];
    logic        m_err    [2];
    logic [31:0] m_rdata  [2];
    logic        m_we     [2];
    logic [31:0] m_adr    [2];
    logic [31:0] m_wd     [2];
    logic [31:0] m_mem    [2][DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_remain[k] <= 0;
                m_ready[k]  <= 1'b0;
                m_busy[k]   <= 1'b0;
                m_err[k]    <= 1'b0;
                m_rdata[k]  <= 32'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                automatic int          old  = m_remain[k];
                automatic int          r    = m_remain[k];
                automatic logic        t_we = m_we[k];
                automatic logic [31:0] t_ad = m_adr[k];
                automatic logic [31:0] t_wd = m_wd[k];
                automatic logic [31:0] rd   = 32'd0;
                automatic logic        er   = 1'b0;
                if (old > 0) begin
                    r = old - 1;
                end else if (req) begin
                    t_we = we;
                    t_ad = adr;
                    t_wd = wdata;
                    m_we[k]  <= we;
                    m_adr[k] <= adr;
                    m_wd[k]  <= wdata;
                    r = lat_of(k) + 1;
                end
                if (r == 1 && old != 1) begin
                    if (t_ad[1:0] != 2'b00 || (t_ad >> 2) >= DEPTH) er = 1'b1;
                    else if (t_we) m_mem[k][t_ad >> 2] <= t_wd;
                    else rd = m_mem[k][t_ad >> 2];
                end
                m_remain[k] <= r;
                m_ready[k]  <= (r == 1);
                m_busy[k]   <= (r > 0);
                m_err[k]    <= er;
                m_rdata[k]  <= rd;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk(k == 0 ? "lat2_ready" : "lat0_ready", 32'(d_ready[k]), 32'(m_ready[k]));
                chk(k == 0 ? "lat2_busy" : "lat0_busy", 32'(d_busy[k]), 32'(m_busy[k]));
                chk(k == 0 ? "lat2_err" : "lat0_err", 32'(d_err[k]), 32'(m_err[k]));
                chk(k == 0 ? "lat2_rdata" : "lat0_rdata", d_rdata[k], m_rdata[k]);
            end
        end
    end

    // One-shot request with literal expectations on both instances; called at a negedge.
    task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_wd,
                       input logic e_err, input logic [31:0] e_rd2, input logic [31:0] e_rd0);
        int          first [2];
        int          rcnt  [2];
        int          bcnt  [2];
        logic [31:0] rd_s  [2];
        logic        er_s  [2];
        for (int k = 0; k < 2; k++) begin
            first[k] = 0; rcnt[k] = 0; bcnt[k] = 0; rd_s[k] = 32'hX; er_s[k] = 1'bX;
        end
        req = 1'b1; we = t_we; adr = t_adr; wdata = t_wd;
        @(negedge clk);
        req = 1'b0; we = 1'($urandom); adr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (d_busy[k]) bcnt[k]++;
                if (d_ready[k]) begin
                    rcnt[k]++;
                    if (first[k] == 0) begin
                        first[k] = c;
                        rd_s[k] = d_rdata[k];
                        er_s[k] = d_err[k];
                    end
                end
            end
        end
        $display("txn we=%0d adr=%h wd=%h: lat2 ready@%0d rd=%h err=%0d | lat0 ready@%0d rd=%h err=%0d",
                 t_we, t_adr, t_wd, first[0], rd_s[0], er_s[0], first[1], rd_s[1], er_s[1]);
        chk("lat2_ready_cycle", 32'(first[0]), 32'd3);
        chk("lat0_ready_cycle", 32'(first[1]), 32'd1);
        chk("lat2_ready_pulses", 32'(rcnt[0]), 32'd1);
        chk("lat0_ready_pulses", 32'(rcnt[1]), 32'd1);
        chk("lat2_busy_cycles", 32'(bcnt[0]), 32'd3);
        chk("lat0_busy_cycles", 32'(bcnt[1]), 32'd1);
        chk("lat2_txn_err", 32'(er_s[0]), 32'(e_err));
        chk("lat0_txn_err", 32'(er_s[1]), 32'(e_err));
        chk("lat2_txn_rdata", rd_s[0], e_rd2);
        chk("lat0_txn_rdata", rd_s[1], e_rd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int p1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(d_ready[k]), 32'd0);
            chk("reset_busy", 32'(d_busy[k]), 32'd0);
            chk("reset_err", 32'(d_err[k]), 32'd0);
            chk("reset_rdata", d_rdata[k], 32'd0);
        end
        cmp_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 16; w++) begin
            txn(1'b1, 32'(w * 4), 32'hA500_0000 + 32'(w), 1'b0, 32'd0, 32'd0);
        end

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        txn(1'b1, 32'h13, 32'h1234_5678, 1'b1, 32'd0, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        txn(1'b0, 32'h1000, 32'd0, 1'b1, 32'd0, 32'd0);

        // Req held high: LATENCY=2 accepts every 4 cycles, LATENCY=0 every 2.
        p0 = 0; p1 = 0;
        req = 1'b1; we = 1'b0; adr = 32'h0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (d_ready[0]) p0++;
            if (d_ready[1]) p1++;
            adr = (c % 2 == 0) ? 32'h4 : 32'h0;
        end
        req = 1'b0;
        $display("held req: lat2 pulses=%0d lat0 pulses=%0d", p0, p1);
        chk("held_lat2_pulses", 32'(p0), 32'd4);
        chk("held_lat0_pulses", 32'(p1), 32'd8);
        repeat (4) @(negedge clk);

        // Reset while the LATENCY=2 write is waiting; LATENCY=0 has already committed.
        req = 1'b1; we = 1'b1; adr = 32'h20; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_lat2_busy", 32'(d_busy[0]), 32'd0);
        chk("abort_lat2_ready", 32'(d_ready[0]), 32'd0);
        chk("abort_lat0_ready", 32'(d_ready[1]), 32'd0);
        chk("abort_lat2_rdata", d_rdata[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ready[0]) p0++;
        end
        $display("abort: lat2 ready pulses after reset=%0d", p0);
        chk("abort_no_ready", 32'(p0), 32'd0);
        txn(1'b0, 32'h20, 32'd0, 1'b0, 32'hA500_0008, 32'hCAFE_F00D);

        for (int i = 0; i < 400; i++) begin
            automatic int sel = $urandom_range(0, 9);
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if (sel == 0) adr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 1) adr = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 1023) * 4)
                                                                  : 32'hFFFF_FFFC;
            else adr = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        req = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
